// File: rtl/jt49_multi_bus.sv
// Multi-PSG bus front end: decodes the AY-style bdir/bc1 bus, keeps readable register
// shadows, queues register writes toward the cores, and mixes the core outputs.
module jt49_multi_bus #(
    parameter int          CHIPS   = 2,
    parameter logic [3:0]  BASE_HI = 4'h0,
    parameter int          DEPTH   = 8,
    parameter int          MIX_W   = 16,
    localparam int         CW      = (CHIPS > 1) ? $clog2(CHIPS) : 1,
    localparam int         LW      = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bdir,
    input  logic                    bc1,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [CW-1:0]           wr_chip,
    output logic [3:0]              wr_addr,
    output logic [7:0]              wr_data,
    output logic [LW-1:0]           level,
    output logic                    overflow,
    input  logic                    ovf_clr,
    input  logic [CHIPS-1:0]        mute,
    input  logic [CHIPS*10-1:0]     core_sound,
    input  logic                    sample,
    output logic signed [MIX_W-1:0] mix,
    output logic                    mix_valid
);

    localparam int AW  = $clog2(DEPTH);
    localparam int NSH = 1 << CW;
    localparam int EW  = CW + 12;

    logic [1:0]    phase;
    logic [3:0]    addr_r;
    logic [CW-1:0] chip_r;
    logic          addr_ok_r;
    logic          prev_wr;
    logic          write_edge;
    logic          wr_accept;
    logic [4:0]    hi_ext;
    logic [4:0]    lo_bound;
    logic [4:0]    hi_bound;

    assign phase      = {bdir, bc1};
    assign write_edge = (phase == 2'b10) && !prev_wr;
    assign wr_accept  = write_edge && addr_ok_r;
    assign hi_ext     = {1'b0, din[7:4]};
    assign lo_bound   = {1'b0, BASE_HI};
    assign hi_bound   = {1'b0, BASE_HI} + 5'(CHIPS);

    // Address latch and write-edge history; 5-bit compare keeps BASE_HI+CHIPS from wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= '0;
            chip_r    <= '0;
            addr_ok_r <= 1'b1;
            prev_wr   <= 1'b0;
        end else begin
            prev_wr <= (phase == 2'b10);
            if (phase == 2'b11) begin
                addr_r    <= din[3:0];
                chip_r    <= CW'(din[7:4] - BASE_HI);
                addr_ok_r <= (hi_ext >= lo_bound) && (hi_ext < hi_bound);
            end
        end
    end

    logic [7:0]      shadow [NSH*16];
    logic [CW+3:0]   sh_idx;
    assign sh_idx = {chip_r, addr_r};

    // Shadow is updated even when the FIFO drops the entry, so reads stay coherent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSH*16; i++) shadow[i] <= '0;
        end else if (wr_accept) begin
            shadow[sh_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout <= 8'hFF;
        else if (phase == 2'b01)
            dout <= addr_ok_r ? shadow[sh_idx] : 8'hFF;
    end

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full, pop, push, drop;

    assign full     = (level == LW'(DEPTH));
    assign wr_valid = (level != '0);
    assign pop      = wr_valid && wr_ready;
    assign push     = wr_accept && (!full || pop);
    assign drop     = wr_accept && full && !pop;
    assign {wr_chip, wr_addr, wr_data} = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {chip_r, addr_r, din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (ovf_clr)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
        end
    end

    logic [11:0]      sum;
    logic [9:0]       s_i;
    logic [MIX_W-1:0] mix_next;

    // Cores are offset-binary around 10'h200; recentre, mute, and sum at 12 bits
    always_comb begin
        sum = '0;
        s_i = '0;
        for (int i = 0; i < CHIPS; i++) begin
            s_i = core_sound[10*i +: 10] - 10'h200;
            if (!mute[i]) sum = sum + {{2{s_i[9]}}, s_i};
        end
        mix_next = MIX_W'($signed(sum)) << (MIX_W - 12);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix       <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= sample;
            if (sample) mix <= mix_next;
        end
    end

endmodule

// File: tb/tb_jt49_multi_bus.sv
// Directed bench for jt49_multi_bus: bus decode, shadow reads, write FIFO, overflow, mixer, reset.
module tb_jt49_multi_bus;

    localparam int CHIPS = 2;
    localparam int DEPTH = 8;
    localparam int MIX_W = 16;
    localparam int CW    = 1;
    localparam int LW    = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    bdir = 1'b0;
    logic                    bc1 = 1'b0;
    logic [7:0]              din = '0;
    logic [7:0]              dout;
    logic                    wr_valid;
    logic                    wr_ready = 1'b0;
    logic [CW-1:0]           wr_chip;
    logic [3:0]              wr_addr;
    logic [7:0]              wr_data;
    logic [LW-1:0]           level;
    logic                    overflow;
    logic                    ovf_clr = 1'b0;
    logic [CHIPS-1:0]        mute = '0;
    logic [CHIPS*10-1:0]     core_sound = '0;
    logic                    sample = 1'b0;
    logic signed [MIX_W-1:0] mix;
    logic                    mix_valid;

    int checks = 0;
    int failures = 0;

    jt49_multi_bus #(
        .CHIPS(CHIPS), .BASE_HI(4'h0), .DEPTH(DEPTH), .MIX_W(MIX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bdir(bdir), .bc1(bc1), .din(din), .dout(dout),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chip(wr_chip), .wr_addr(wr_addr),
        .wr_data(wr_data), .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
        .mute(mute), .core_sound(core_sound), .sample(sample), .mix(mix), .mix_valid(mix_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] ph, input logic [7:0] d);
        {bdir, bc1} = ph;
        din = d;
        cyc();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        checks++; if (dout !== 8'hFF) begin failures++; $display("[TB] FAIL reset_dout: got %h expected ff", dout); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (mix !== 16'h0000) begin failures++; $display("[TB] FAIL reset_mix: got %h expected 0000", mix); end
        checks++; if (mix_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mix_valid: got %b expected 0", mix_valid); end
        rst_n = 1'b1;
        bus(2'b01, 8'h00);
        checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL first_read_after_reset: got %h expected 00", dout); end
        bus(2'b00, 8'h00);
    endtask

    task automatic test_single_write();
        int peak;
        peak = 0;
        wr_ready = 1'b1;
        bus(2'b11, 8'h05);
        bus(2'b10, 8'hAB);
        checks++; if (level !== 4'd1) begin failures++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
        checks++; if ({wr_valid, wr_chip, wr_addr, wr_data} !== {1'b1, 1'b0, 4'h5, 8'hAB})
            begin failures++; $display("[TB] FAIL single_head: got v=%b c=%h a=%h d=%h expected v=1 c=0 a=5 d=ab", wr_valid, wr_chip, wr_addr, wr_data); end
        for (int k = 0; k < 2; k++) begin
            bus(2'b10, 8'hAB);
            if (int'(level) > peak) peak = int'(level);
        end
        checks++; if (peak !== 0) begin failures++; $display("[TB] FAIL single_one_push: got level %0d expected 0 while write held", peak); end
        bus(2'b00, 8'h00);
        wr_ready = 1'b0;
    endtask

    task automatic test_read_shadow();
        bus(2'b11, 8'h1C);
        bus(2'b10, 8'h33);
        bus(2'b01, 8'h00);
        checks++; if (dout !== 8'h33) begin failures++; $display("[TB] FAIL read_after_write: got %h expected 33", dout); end
        checks++; if ({wr_valid, wr_chip, wr_addr, wr_data} !== {1'b1, 1'b1, 4'hC, 8'h33})
            begin failures++; $display("[TB] FAIL pending_head: got v=%b c=%h a=%h d=%h expected v=1 c=1 a=c d=33", wr_valid, wr_chip, wr_addr, wr_data); end
        bus(2'b11, 8'h2C);
        bus(2'b01, 8'h00);
        checks++; if (dout !== 8'hFF) begin failures++; $display("[TB] FAIL read_bad_chip: got %h expected ff", dout); end
        bus(2'b10, 8'h55);
        checks++; if (level !== 4'd1) begin failures++; $display("[TB] FAIL bad_chip_no_push: got %0d expected 1", level); end
        bus(2'b11, 8'h0C);
        bus(2'b01, 8'h00);
        checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL bad_chip_no_shadow: got %h expected 00", dout); end
        bus(2'b11, 8'h05);
        bus(2'b01, 8'h00);
        checks++; if (dout !== 8'hAB) begin failures++; $display("[TB] FAIL read_chip0: got %h expected ab", dout); end
        wr_ready = 1'b1;
        bus(2'b00, 8'h00);
        wr_ready = 1'b0;
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL drain_level: got %0d expected 0", level); end
    endtask

    task automatic test_overflow();
        bus(2'b11, 8'h00);
        for (int i = 0; i <= DEPTH; i++) begin
            bus(2'b10, 8'h10 + 8'(i));
            bus(2'b00, 8'h00);
        end
        checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL ovf_level: got %0d expected 8", level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (wr_data !== 8'h10) begin failures++; $display("[TB] FAIL ovf_head: got %h expected 10", wr_data); end
        ovf_clr = 1'b1;
        bus(2'b10, 8'h20);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear_wins: got %b expected 0", overflow); end
        checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL ovf_drop_level: got %0d expected 8", level); end
        bus(2'b01, 8'h00);
        checks++; if (dout !== 8'h20) begin failures++; $display("[TB] FAIL dropped_shadow: got %h expected 20", dout); end
        bus(2'b00, 8'h00);
    endtask

    task automatic test_full_pop();
        logic [7:0] exp;
        wr_ready = 1'b1;
        bus(2'b10, 8'h30);
        wr_ready = 1'b0;
        {bdir, bc1} = 2'b00;
        checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL fullpop_level: got %0d expected 8", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL fullpop_overflow: got %b expected 0", overflow); end
        for (int k = 0; k < DEPTH; k++) begin
            exp = (k < DEPTH - 1) ? 8'h11 + 8'(k) : 8'h30;
            checks++; if (wr_data !== exp) begin failures++; $display("[TB] FAIL fullpop_order[%0d]: got %h expected %h", k, wr_data, exp); end
            wr_ready = 1'b1;
            bus(2'b00, 8'h00);
        end
        wr_ready = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("[TB] FAIL fullpop_empty: got %b expected 0", wr_valid); end
    endtask

    task automatic test_mixer();
        core_sound = {10'h3FF, 10'h000};
        mute = 2'b00;
        sample = 1'b1; cyc(); sample = 1'b0;
        checks++; if (mix_valid !== 1'b1) begin failures++; $display("[TB] FAIL mix_valid_pulse: got %b expected 1", mix_valid); end
        checks++; if (mix !== 16'hFFF0) begin failures++; $display("[TB] FAIL mix_minus1: got %h expected fff0", mix); end
        cyc();
        checks++; if (mix_valid !== 1'b0) begin failures++; $display("[TB] FAIL mix_valid_drop: got %b expected 0", mix_valid); end
        checks++; if (mix !== 16'hFFF0) begin failures++; $display("[TB] FAIL mix_hold: got %h expected fff0", mix); end
        mute = 2'b01;
        sample = 1'b1; cyc(); sample = 1'b0;
        checks++; if (mix !== 16'h1FF0) begin failures++; $display("[TB] FAIL mix_mute0: got %h expected 1ff0", mix); end
        mute = 2'b00;
        core_sound = {10'h000, 10'h000};
        sample = 1'b1; cyc(); sample = 1'b0;
        checks++; if (mix !== 16'hC000) begin failures++; $display("[TB] FAIL mix_min: got %h expected c000", mix); end
        core_sound = {10'h3FF, 10'h3FF};
        sample = 1'b1; cyc(); sample = 1'b0;
        checks++; if (mix !== 16'h3FE0) begin failures++; $display("[TB] FAIL mix_max: got %h expected 3fe0", mix); end
        mute = 2'b11;
        sample = 1'b1; cyc(); sample = 1'b0;
        checks++; if (mix !== 16'h0000) begin failures++; $display("[TB] FAIL mix_all_muted: got %h expected 0000", mix); end
        mute = 2'b00;
    endtask

    task automatic test_reset_mid();
        core_sound = {10'h000, 10'h000};
        sample = 1'b1; cyc(); sample = 1'b0;
        wr_ready = 1'b0;
        bus(2'b11, 8'h03);
        for (int i = 0; i < 3; i++) begin
            bus(2'b10, 8'h40 + 8'(i));
            bus(2'b00, 8'h00);
        end
        checks++; if (level !== 4'd3) begin failures++; $display("[TB] FAIL pre_reset_level: got %0d expected 3", level); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL async_level: got %0d expected 0", level); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (mix !== 16'h0000) begin failures++; $display("[TB] FAIL async_mix: got %h expected 0000", mix); end
        checks++; if (dout !== 8'hFF) begin failures++; $display("[TB] FAIL async_dout: got %h expected ff", dout); end
        cyc();
        rst_n = 1'b1;
        bus(2'b01, 8'h00);
        checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL shadow_cleared: got %h expected 00", dout); end
        bus(2'b00, 8'h00);
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("[TB] FAIL fifo_discarded: got %b expected 0", wr_valid); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_shadow();
        test_overflow();
        test_full_pop();
        test_mixer();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
